mac_tree_pipe: RTL and testbench

- Pipelined, parametrised dot-product MAC: `lanes` unsigned-activation × signed-weight products, a registered adder tree, then a final saturating add of either an external partial sum or its own running accumulator.
- Successor to the fixed 4-lane combinational MAC/adder-tree wrapper.
- Used as the PE compute core inside the systolic/OS array; it adds valid tracking, in-place accumulation and saturation.

---
 rtl/mac_tree_pipe.sv | 133 +++++++++++++
 tb/tb_mac_tree_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tree_pipe.sv
// mac_tree_pipe: pipelined dot-product MAC used as the PE compute core.
// Stage 0 forms lanes unsigned-x by signed-w products, log2(lanes) registered
// adder-tree stages reduce them, and a final stage adds either the external
// partial sum or the running accumulator (out) with saturation.
// Every beat carries its valid bit and acc/psum_in sideband down the pipe.
module mac_tree_pipe #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [lanes*bw-1:0]     x,
  input  logic [lanes*bw-1:0]     w,
  input  logic [psum_bw-1:0]      psum_in,
  input  logic                    acc,
  output logic                    out_valid,
  output logic [psum_bw-1:0]      out
);

  localparam int levels = $clog2(lanes);
  // Product width: (bw+1) x (bw+1) signed operands.
  localparam int pw = 2*bw + 2;
  // Tree node storage width: wide enough for the root, so no truncation anywhere.
  localparam int tw = pw + levels;
  // Final adder width: two guard bits above the output width.
  localparam int sw = psum_bw + 2;

  // Leaf products, held sign-extended to the tree width.
  logic [tw-1:0] prod_q [lanes];
  logic [pw-1:0] prod_d [lanes];

  // Internal tree nodes, level by level: level k occupies
  // indices [lanes - (lanes >> (k-1)) +: (lanes >> k)]; the root is at lanes-2.
  logic [tw-1:0] sum_q [lanes-1];

  // Sideband travelling with each beat: index k is the stage-k register.
  logic [levels:0]    valid_q;
  logic [levels:0]    acc_q;
  logic [psum_bw-1:0] psum_q [levels+1];

  // Final-stage combinational signals.
  logic [psum_bw-1:0] addend;
  logic [sw-1:0]      addend_ext;
  logic [sw-1:0]      tree_ext;
  logic [sw-1:0]      total;
  logic [2:0]         guard;
  logic               in_range;
  logic [psum_bw-1:0] sat_out;

  // Per-lane products: x zero-extended, w sign-extended, both widened to pw
  // so the low pw bits of the unsigned multiply are the exact signed product.
  always_comb begin
    logic [bw-1:0] xl;
    logic [bw-1:0] wl;
    logic [pw-1:0] xe;
    logic [pw-1:0] we;
    for (int i = 0; i < lanes; i++) begin
      xl = x[i*bw +: bw];
      wl = w[i*bw +: bw];
      xe = {{(bw+2){1'b0}}, xl};
      we = {{(bw+2){wl[bw-1]}}, wl};
      prod_d[i] = xe * we;
    end
  end

  // Stage 0: register the products sign-extended to the tree width.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < lanes; i++) prod_q[i] <= '0;
    end else begin
      for (int i = 0; i < lanes; i++)
        prod_q[i] <= {{levels{prod_d[i][pw-1]}}, prod_d[i]};
    end
  end

  // Tree stages 1..levels: each level sums adjacent pairs of the level below.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < lanes-1; n++) sum_q[n] <= '0;
    end else begin
      for (int i = 0; i < lanes/2; i++)
        sum_q[i] <= prod_q[2*i] + prod_q[2*i+1];
      for (int k = 2; k <= levels; k++)
        for (int i = 0; i < (lanes >> k); i++)
          sum_q[lanes - (lanes >> (k-1)) + i] <=
            sum_q[lanes - (lanes >> (k-2)) + 2*i] +
            sum_q[lanes - (lanes >> (k-2)) + 2*i + 1];
    end
  end

  // Sideband shift register so valid/acc/psum_in stay aligned with the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      acc_q   <= '0;
      for (int k = 0; k <= levels; k++) psum_q[k] <= '0;
    end else begin
      valid_q <= {valid_q[levels-1:0], in_valid};
      acc_q   <= {acc_q[levels-1:0], acc};
      psum_q[0] <= psum_in;
      for (int k = 1; k <= levels; k++) psum_q[k] <= psum_q[k-1];
    end
  end

  // Final add: pick the addend, widen both operands, and clamp on overflow
  // (the three top bits of the wide sum disagree only when out of range).
  always_comb begin
    addend     = acc_q[levels] ? out : psum_q[levels];
    addend_ext = {{2{addend[psum_bw-1]}}, addend};
    tree_ext   = {{(sw-tw){sum_q[lanes-2][tw-1]}}, sum_q[lanes-2]};
    total      = addend_ext + tree_ext;
    guard      = total[sw-1:psum_bw-1];
    in_range   = (&guard) | ~(|guard);
    sat_out    = total[psum_bw-1:0];
    if (!in_range)
      sat_out = total[sw-1] ? {1'b1, {(psum_bw-1){1'b0}}}
                            : {1'b0, {(psum_bw-1){1'b1}}};
  end

  // Output register: only valid beats update out, so bubbles leave it intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= valid_q[levels];
      if (valid_q[levels]) out <= sat_out;
    end
  end

endmodule

// File: tb/tb_mac_tree_pipe.sv
// tb_mac_tree_pipe: directed and random checks of mac_tree_pipe in two
// configurations (4 lanes/4-bit/16-bit and 8 lanes/8-bit/24-bit). A reference
// model computes each result from plain integer arithmetic when the beat is
// due to emerge; outputs are compared every cycle, 1 time unit after the edge.
module tb_mac_tree_pipe;

  // Edges after the sampling edge at which the result appears (L+1).
  localparam int LAT0 = 3;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  logic reset;

  logic        v0, acc0, ov0;
  logic [15:0] x0, w0, ps0, out0;

  logic        v1, acc1, ov1;
  logic [63:0] x1, w1;
  logic [23:0] ps1, out1;

  typedef struct packed {
    logic [63:0] xv;
    logic [63:0] wv;
    logic [23:0] ps;
    logic        accf;
    int          issue;
  } beat_t;

  beat_t  q0[$];
  beat_t  q1[$];
  longint m0, m1;
  int     cyc;
  int     checks;
  int     passes;

  mac_tree_pipe #(.bw(4), .psum_bw(16), .lanes(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v0), .x(x0), .w(w0),
    .psum_in(ps0), .acc(acc0), .out_valid(ov0), .out(out0)
  );

  mac_tree_pipe #(.bw(8), .psum_bw(24), .lanes(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v1), .x(x1), .w(w1),
    .psum_in(ps1), .acc(acc1), .out_valid(ov1), .out(out1)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Dot product of unsigned x and signed w lanes plus addend, clamped to psum range.
  function automatic longint ref_result(int nl, int b, int pb, logic [63:0] xv,
                                        logic [63:0] wv, logic [23:0] ps,
                                        logic accf, longint prev);
    longint s, mask, pmask, xi, wi, add, hi, lo;
    mask  = (longint'(1) << b) - 1;
    pmask = (longint'(1) << pb) - 1;
    s = 0;
    for (int i = 0; i < nl; i++) begin
      xi = longint'(xv >> (i*b)) & mask;
      wi = longint'(wv >> (i*b)) & mask;
      if (wi >= (longint'(1) << (b-1))) wi = wi - (longint'(1) << b);
      s = s + xi * wi;
    end
    if (accf) add = prev;
    else begin
      add = longint'(ps) & pmask;
      if (add >= (longint'(1) << (pb-1))) add = add - (longint'(1) << pb);
    end
    s  = s + add;
    hi = (longint'(1) << (pb-1)) - 1;
    lo = -(longint'(1) << (pb-1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: record sampled beats, retire due beats through the model, compare.
  task automatic tick();
    beat_t       b;
    logic        ev0, ev1;
    logic [15:0] e0;
    logic [23:0] e1;
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      q0.delete();
      q1.delete();
      m0 = 0;
      m1 = 0;
    end else begin
      if (v0) begin
        b.xv = 64'(x0); b.wv = 64'(w0); b.ps = 24'(ps0); b.accf = acc0; b.issue = cyc;
        q0.push_back(b);
      end
      if (v1) begin
        b.xv = x1; b.wv = w1; b.ps = ps1; b.accf = acc1; b.issue = cyc;
        q1.push_back(b);
      end
    end
    ev0 = 1'b0;
    if (q0.size() > 0 && q0[0].issue + LAT0 == cyc) begin
      m0  = ref_result(4, 4, 16, q0[0].xv, q0[0].wv, q0[0].ps, q0[0].accf, m0);
      ev0 = 1'b1;
      void'(q0.pop_front());
    end
    ev1 = 1'b0;
    if (q1.size() > 0 && q1[0].issue + LAT1 == cyc) begin
      m1  = ref_result(8, 8, 24, q1[0].xv, q1[0].wv, q1[0].ps, q1[0].accf, m1);
      ev1 = 1'b1;
      void'(q1.pop_front());
    end
    e0 = m0[15:0];
    e1 = m1[23:0];
    checkOutput("dut4 out_valid", 64'(ov0), 64'(ev0));
    checkOutput("dut4 out", 64'(out0), 64'(e0));
    checkOutput("dut8 out_valid", 64'(ov1), 64'(ev1));
    checkOutput("dut8 out", 64'(out1), 64'(e1));
  endtask

  // Present one valid beat to the 4-lane instance for a single cycle.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] w,
                               input logic [15:0] ps, input logic a);
    v0 = 1'b1; x0 = x; w0 = w; ps0 = ps; acc0 = a;
    tick();
    v0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; m0 = 0; m1 = 0;
    reset = 1'b1;
    v0 = 1'b0; acc0 = 1'b0; x0 = '0; w0 = '0; ps0 = '0;
    v1 = 1'b0; acc1 = 1'b0; x1 = '0; w1 = '0; ps1 = '0;

    // Reset state
    idle(2);
    reset = 1'b0;
    idle(2);

    // Basic: 1+2+3+4 plus 10
    applyStimulus(16'h4321, 16'h1111, 16'd10, 1'b0);
    idle(6);
    checkOutput("basic held", 64'(out0), 64'd20);

    // Signed extremes: -480 then 419
    applyStimulus(16'hFFFF, 16'h8888, 16'h0000, 1'b0);
    applyStimulus(16'hFFFF, 16'h7777, 16'hFFFF, 1'b0);
    idle(5);
    checkOutput("signed held", 64'(out0), 64'd419);

    // Saturation both ways, then an in-range beat
    applyStimulus(16'hFFFF, 16'h7777, 16'h7FFF, 1'b0);
    applyStimulus(16'hFFFF, 16'h8888, 16'h8000, 1'b0);
    applyStimulus(16'h0001, 16'h0001, 16'd5, 1'b0);
    idle(5);
    checkOutput("sat not sticky", 64'(out0), 64'd6);

    // Accumulate back-to-back: 104, 108, 112 (psum_in ignored when acc=1)
    applyStimulus(16'h1111, 16'h1111, 16'd100, 1'b0);
    applyStimulus(16'h1111, 16'h1111, 16'h1234, 1'b1);
    applyStimulus(16'h1111, 16'h1111, 16'h4321, 1'b1);
    idle(5);
    checkOutput("acc chain", 64'(out0), 64'd112);

    // Accumulate with bubbles, invalid beats carrying acc/psum noise
    applyStimulus(16'h1111, 16'h1111, 16'd100, 1'b0);
    acc0 = 1'b0; ps0 = 16'h7FFF;
    idle(3);
    applyStimulus(16'h1111, 16'h1111, 16'h0000, 1'b1);
    acc0 = 1'b1;
    idle(3);
    applyStimulus(16'h1111, 16'h1111, 16'h0000, 1'b1);
    idle(6);
    checkOutput("acc bubbles", 64'(out0), 64'd112);

    // Reset while the first of three beats sits in tree stage 1
    applyStimulus(16'hFFFF, 16'h7777, 16'd1, 1'b0);
    applyStimulus(16'hFFFF, 16'h7777, 16'd2, 1'b0);
    v0 = 1'b1; x0 = 16'hFFFF; w0 = 16'h7777; ps0 = 16'd3; acc0 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = 1'b0;
    idle(6);
    checkOutput("reset flush", 64'(out0), 64'd0);

    // First beat after reset with acc=1 accumulates onto 0
    applyStimulus(16'h4321, 16'h1111, 16'd999, 1'b1);
    idle(5);
    checkOutput("acc after reset", 64'(out0), 64'd10);

    // 8-lane instance: all ones plus 5
    v1 = 1'b1; x1 = 64'h0101010101010101; w1 = 64'h0101010101010101;
    ps1 = 24'd5; acc1 = 1'b0;
    tick();
    v1 = 1'b0;
    idle(6);
    checkOutput("dut8 basic", 64'(out1), 64'd13);

    // Random back-to-back beats on both instances
    for (int i = 0; i < 16; i++) begin
      v0 = 1'b1; x0 = 16'($urandom); w0 = 16'($urandom);
      ps0 = 16'($urandom); acc0 = 1'($urandom);
      v1 = 1'b1; x1 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
      ps1 = 24'($urandom); acc1 = 1'($urandom);
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    idle(8);

    // Random sparse traffic with random bubbles
    for (int i = 0; i < 24; i++) begin
      v0 = 1'($urandom); x0 = 16'($urandom); w0 = 16'($urandom);
      ps0 = 16'($urandom); acc0 = 1'($urandom);
      v1 = 1'($urandom); x1 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
      ps1 = 24'($urandom); acc1 = 1'($urandom);
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
